// File: rtl/lab2_proc_fetch_squash_unit_pkg.sv
// Shared types and helpers for the fetch squash unit: imem response layout
// and counter sizing.
package lab2_proc_fetch_squash_unit_pkg;

   typedef struct packed {
      logic [2:0]  msg_type;
      logic [7:0]  opaque;
      logic [1:0]  test;
      logic [1:0]  len;
      logic [31:0] data;
   } mem_resp_4B_t;

   // Bits needed to hold the values 0..max inclusive
   function automatic int unsigned cnt_nbits(input int unsigned max);
      return $clog2(max + 1);
   endfunction

endpackage

// File: rtl/lab2_proc_updown_counter.sv
// Up/down counter with a parallel load and an asynchronous active-low clear.
// Saturates at zero on a lone decrement so it cannot wrap below 0.
module lab2_proc_updown_counter #(
   parameter int unsigned p_nbits = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               inc_i,
   input  logic               dec_i,
   input  logic               load_i,
   input  logic [p_nbits-1:0] load_val_i,
   output logic [p_nbits-1:0] cnt_o
);

   logic [p_nbits-1:0] cnt_q;
   logic [p_nbits-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && !inc_i && (cnt_q == '0)) begin
         cnt_d = cnt_q;
      end else begin
         cnt_d = cnt_q + p_nbits'(inc_i) - p_nbits'(dec_i);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/lab2_proc_fetch_squash_unit.sv
// Sits between fetch and the imem ports: credit-limits outstanding requests
// and discards responses to requests that were in flight when a squash hit.
module lab2_proc_fetch_squash_unit
   import lab2_proc_fetch_squash_unit_pkg::*;
#(
   parameter  int unsigned p_msg_nbits    = $bits(mem_resp_4B_t),
   parameter  int unsigned p_max_inflight = 2,
   localparam int unsigned c_cnt_nbits    = cnt_nbits(p_max_inflight)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   squash,
   input  logic                   req_in_val,
   output logic                   req_in_rdy,
   output logic                   req_out_val,
   input  logic                   req_out_rdy,
   input  logic [p_msg_nbits-1:0] resp_in_msg,
   input  logic                   resp_in_val,
   output logic                   resp_in_rdy,
   output logic [p_msg_nbits-1:0] resp_out_msg,
   output logic                   resp_out_val,
   input  logic                   resp_out_rdy,
   output logic [c_cnt_nbits-1:0] num_inflight,
   output logic [c_cnt_nbits-1:0] num_drop
);

   logic [c_cnt_nbits-1:0] inflight_cnt;
   logic [c_cnt_nbits-1:0] drop_cnt;
   logic [c_cnt_nbits-1:0] drop_load_val;
   logic                   credit_ok;
   logic                   drop_now;
   logic                   req_fire;
   logic                   resp_fire;
   logic                   drop_dec;

   // Request side only sees the registered count, never the live response
   assign credit_ok   = (inflight_cnt < c_cnt_nbits'(p_max_inflight));
   assign req_out_val = reset & req_in_val & credit_ok;
   assign req_in_rdy  = reset & req_out_rdy & credit_ok;
   assign req_fire    = req_in_val & req_in_rdy;

   assign drop_now     = squash | (drop_cnt != '0);
   assign resp_out_msg = resp_in_msg;
   assign resp_out_val = reset & ~drop_now & resp_in_val;
   assign resp_in_rdy  = reset & (drop_now | resp_out_rdy);
   assign resp_fire    = resp_in_val & resp_in_rdy;

   // Squash reloads with everything older than this cycle, minus a response dropped now
   assign drop_load_val = (inflight_cnt == '0) ? '0
                        : inflight_cnt - c_cnt_nbits'(resp_fire);
   assign drop_dec      = (drop_cnt != '0) & resp_fire;

   lab2_proc_updown_counter #(.p_nbits(c_cnt_nbits)) u_inflight_cnt (
      .clk        (clk),
      .rst_n      (reset),
      .inc_i      (req_fire),
      .dec_i      (resp_fire),
      .load_i     (1'b0),
      .load_val_i ('0),
      .cnt_o      (inflight_cnt)
   );

   lab2_proc_updown_counter #(.p_nbits(c_cnt_nbits)) u_drop_cnt (
      .clk        (clk),
      .rst_n      (reset),
      .inc_i      (1'b0),
      .dec_i      (drop_dec),
      .load_i     (squash),
      .load_val_i (drop_load_val),
      .cnt_o      (drop_cnt)
   );

   assign num_inflight = inflight_cnt;
   assign num_drop     = drop_cnt;

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (reset && resp_in_val) begin
         assert (inflight_cnt != '0)
            else $error("imem response arrived with no request in flight");
      end
      if (reset) begin
         assert (drop_cnt <= inflight_cnt)
            else $error("pending drops exceed outstanding requests");
      end
   end
`endif

endmodule

// File: tb/tb_lab2_proc_fetch_squash_unit.sv
// Directed bench for the fetch squash unit: one instance at the default
// credit limit of 2 and one at 4 for the same-cycle and repeated squash cases.
module tb_lab2_proc_fetch_squash_unit;

   localparam int unsigned MSG = 47;
   localparam int unsigned W2  = 2;
   localparam int unsigned W4  = 3;

   logic clk;
   logic reset;

   logic           squash, req_in_val, req_in_rdy, req_out_val, req_out_rdy;
   logic [MSG-1:0] resp_in_msg, resp_out_msg;
   logic           resp_in_val, resp_in_rdy, resp_out_val, resp_out_rdy;
   logic [W2-1:0]  num_inflight, num_drop;

   logic           squash4, req_in_val4, req_in_rdy4, req_out_val4, req_out_rdy4;
   logic [MSG-1:0] resp_in_msg4, resp_out_msg4;
   logic           resp_in_val4, resp_in_rdy4, resp_out_val4, resp_out_rdy4;
   logic [W4-1:0]  num_inflight4, num_drop4;

   int n_checks = 0;
   int n_errors = 0;

   lab2_proc_fetch_squash_unit #(.p_msg_nbits(MSG), .p_max_inflight(2)) dut (
      .clk(clk), .reset(reset), .squash(squash),
      .req_in_val(req_in_val), .req_in_rdy(req_in_rdy),
      .req_out_val(req_out_val), .req_out_rdy(req_out_rdy),
      .resp_in_msg(resp_in_msg), .resp_in_val(resp_in_val), .resp_in_rdy(resp_in_rdy),
      .resp_out_msg(resp_out_msg), .resp_out_val(resp_out_val), .resp_out_rdy(resp_out_rdy),
      .num_inflight(num_inflight), .num_drop(num_drop)
   );

   lab2_proc_fetch_squash_unit #(.p_msg_nbits(MSG), .p_max_inflight(4)) dut4 (
      .clk(clk), .reset(reset), .squash(squash4),
      .req_in_val(req_in_val4), .req_in_rdy(req_in_rdy4),
      .req_out_val(req_out_val4), .req_out_rdy(req_out_rdy4),
      .resp_in_msg(resp_in_msg4), .resp_in_val(resp_in_val4), .resp_in_rdy(resp_in_rdy4),
      .resp_out_msg(resp_out_msg4), .resp_out_val(resp_out_val4), .resp_out_rdy(resp_out_rdy4),
      .num_inflight(num_inflight4), .num_drop(num_drop4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0;
      squash = 1'b0; req_in_val = 1'b1; req_out_rdy = 1'b1;
      resp_in_msg = '0; resp_in_val = 1'b0; resp_out_rdy = 1'b1;
      squash4 = 1'b0; req_in_val4 = 1'b0; req_out_rdy4 = 1'b1;
      resp_in_msg4 = '0; resp_in_val4 = 1'b0; resp_out_rdy4 = 1'b1;

      // Reset forces handshakes low even with requests pending
      #2;
      chk("rst_req_in_rdy",   64'(req_in_rdy),   64'd0);
      chk("rst_req_out_val",  64'(req_out_val),  64'd0);
      chk("rst_resp_in_rdy",  64'(resp_in_rdy),  64'd0);
      chk("rst_resp_out_val", 64'(resp_out_val), 64'd0);
      chk("rst_inflight",     64'(num_inflight), 64'd0);
      chk("rst_drop",         64'(num_drop),     64'd0);
      @(negedge clk);
      reset = 1'b1;
      req_in_val = 1'b0;
      cyc();

      // Pass-through and credit limit at 2
      req_in_val = 1'b1;
      #2;
      chk("t1_req_out_val", 64'(req_out_val), 64'd1);
      chk("t1_req_in_rdy",  64'(req_in_rdy),  64'd1);
      cyc();
      chk("t1_inflight1", 64'(num_inflight), 64'd1);
      cyc();
      chk("t1_inflight2", 64'(num_inflight), 64'd2);
      #2;
      chk("t1_full_rdy", 64'(req_in_rdy),  64'd0);
      chk("t1_full_val", 64'(req_out_val), 64'd0);
      cyc();
      chk("t1_held2", 64'(num_inflight), 64'd2);
      req_in_val = 1'b0;
      resp_in_val = 1'b1; resp_in_msg = MSG'(64'hA);
      #2;
      chk("t1_respA_val", 64'(resp_out_val), 64'd1);
      chk("t1_respA_msg", 64'(resp_out_msg), 64'hA);
      cyc();
      chk("t1_inflight_a", 64'(num_inflight), 64'd1);
      resp_in_msg = MSG'(64'hB);
      #2;
      chk("t1_respB_val", 64'(resp_out_val), 64'd1);
      chk("t1_respB_msg", 64'(resp_out_msg), 64'hB);
      cyc();
      resp_in_val = 1'b0;
      chk("t1_inflight_b", 64'(num_inflight), 64'd0);

      // Squash with 2 in flight, drop mode ignores downstream backpressure
      req_in_val = 1'b1;
      cyc(); cyc();
      req_in_val = 1'b0;
      chk("t2_inflight", 64'(num_inflight), 64'd2);
      squash = 1'b1; resp_out_rdy = 1'b0;
      #2;
      chk("t2_sq_resp_in_rdy", 64'(resp_in_rdy), 64'd1);
      cyc();
      squash = 1'b0;
      chk("t2_drop2",     64'(num_drop),     64'd2);
      chk("t2_inflight2", 64'(num_inflight), 64'd2);
      resp_in_val = 1'b1; resp_in_msg = MSG'(64'h77);
      #2;
      chk("t2_d1_out_val", 64'(resp_out_val), 64'd0);
      chk("t2_d1_in_rdy",  64'(resp_in_rdy),  64'd1);
      cyc();
      chk("t2_drop1", 64'(num_drop), 64'd1);
      resp_out_rdy = 1'b1; resp_in_msg = MSG'(64'h78);
      #2;
      chk("t2_d2_out_val", 64'(resp_out_val), 64'd0);
      cyc();
      resp_in_val = 1'b0;
      chk("t2_drop0",     64'(num_drop),     64'd0);
      chk("t2_inflight0", 64'(num_inflight), 64'd0);
      req_in_val = 1'b1;
      cyc();
      req_in_val = 1'b0;
      resp_in_val = 1'b1; resp_in_msg = MSG'(64'hC);
      #2;
      chk("t2_respC_val", 64'(resp_out_val), 64'd1);
      chk("t2_respC_msg", 64'(resp_out_msg), 64'hC);
      cyc();
      resp_in_val = 1'b0;
      chk("t2_end_inflight", 64'(num_inflight), 64'd0);

      // Normal-mode backpressure stalls the response
      req_in_val = 1'b1;
      cyc();
      req_in_val = 1'b0;
      resp_in_val = 1'b1; resp_in_msg = MSG'(64'h5); resp_out_rdy = 1'b0;
      #2;
      chk("t5_out_val", 64'(resp_out_val), 64'd1);
      chk("t5_in_rdy",  64'(resp_in_rdy),  64'd0);
      cyc();
      chk("t5_held", 64'(num_inflight), 64'd1);
      resp_out_rdy = 1'b1;
      #2;
      chk("t5_in_rdy_go", 64'(resp_in_rdy), 64'd1);
      cyc();
      resp_in_val = 1'b0;
      chk("t5_inflight0", 64'(num_inflight), 64'd0);

      // MAX=4: squash with same-cycle response and same-cycle request
      req_in_val4 = 1'b1;
      cyc(); cyc();
      chk("t3_inflight2", 64'(num_inflight4), 64'd2);
      squash4 = 1'b1; resp_in_val4 = 1'b1; resp_in_msg4 = MSG'(64'h66);
      #2;
      chk("t3_sq_out_val", 64'(resp_out_val4), 64'd0);
      chk("t3_sq_req_rdy", 64'(req_in_rdy4),   64'd1);
      chk("t3_sq_in_rdy",  64'(resp_in_rdy4),  64'd1);
      cyc();
      squash4 = 1'b0; req_in_val4 = 1'b0;
      chk("t3_inflight", 64'(num_inflight4), 64'd2);
      chk("t3_drop1",    64'(num_drop4),     64'd1);
      resp_in_msg4 = MSG'(64'h67);
      #2;
      chk("t3_d_out_val", 64'(resp_out_val4), 64'd0);
      cyc();
      chk("t3_drop0",     64'(num_drop4),     64'd0);
      chk("t3_inflight1", 64'(num_inflight4), 64'd1);
      resp_in_msg4 = MSG'(64'hE);
      #2;
      chk("t3_respE_val", 64'(resp_out_val4), 64'd1);
      chk("t3_respE_msg", 64'(resp_out_msg4), 64'hE);
      cyc();
      resp_in_val4 = 1'b0;
      chk("t3_inflight0", 64'(num_inflight4), 64'd0);

      // MAX=4: repeated squash reloads rather than accumulates
      req_in_val4 = 1'b1;
      cyc(); cyc(); cyc();
      req_in_val4 = 1'b0;
      chk("t4_inflight3", 64'(num_inflight4), 64'd3);
      squash4 = 1'b1;
      cyc();
      squash4 = 1'b0;
      chk("t4_drop3", 64'(num_drop4), 64'd3);
      resp_in_val4 = 1'b1; resp_in_msg4 = MSG'(64'h10);
      #2;
      chk("t4_d_out_val", 64'(resp_out_val4), 64'd0);
      cyc();
      resp_in_val4 = 1'b0;
      chk("t4_drop2a",     64'(num_drop4),     64'd2);
      chk("t4_inflight2a", 64'(num_inflight4), 64'd2);
      squash4 = 1'b1;
      cyc();
      squash4 = 1'b0;
      chk("t4_reload2",    64'(num_drop4),     64'd2);
      chk("t4_inflight2b", 64'(num_inflight4), 64'd2);
      resp_in_val4 = 1'b1;
      cyc();
      chk("t4_drop1", 64'(num_drop4), 64'd1);
      cyc();
      resp_in_val4 = 1'b0;
      chk("t4_drop0",     64'(num_drop4),     64'd0);
      chk("t4_inflight0", 64'(num_inflight4), 64'd0);
      req_in_val4 = 1'b1;
      cyc();
      req_in_val4 = 1'b0;
      resp_in_val4 = 1'b1; resp_in_msg4 = MSG'(64'hF);
      #2;
      chk("t4_respF_val", 64'(resp_out_val4), 64'd1);
      chk("t4_respF_msg", 64'(resp_out_msg4), 64'hF);
      cyc();
      resp_in_val4 = 1'b0;
      chk("t4_end_inflight", 64'(num_inflight4), 64'd0);

      // Reset mid-operation with 2 in flight and 1 pending drop
      req_in_val = 1'b1;
      cyc();
      chk("t6_inflight1", 64'(num_inflight), 64'd1);
      squash = 1'b1;
      #2;
      chk("t6_sq_req_rdy", 64'(req_in_rdy), 64'd1);
      cyc();
      squash = 1'b0;
      chk("t6_inflight2", 64'(num_inflight), 64'd2);
      chk("t6_drop1",     64'(num_drop),     64'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("t6_rst_inflight",     64'(num_inflight), 64'd0);
      chk("t6_rst_drop",         64'(num_drop),     64'd0);
      chk("t6_rst_req_in_rdy",   64'(req_in_rdy),   64'd0);
      chk("t6_rst_req_out_val",  64'(req_out_val),  64'd0);
      chk("t6_rst_resp_in_rdy",  64'(resp_in_rdy),  64'd0);
      chk("t6_rst_resp_out_val", 64'(resp_out_val), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      req_in_val = 1'b0;
      cyc();
      chk("t6_post_inflight", 64'(num_inflight), 64'd0);
      req_in_val = 1'b1;
      cyc();
      req_in_val = 1'b0;
      chk("t6_req_inflight", 64'(num_inflight), 64'd1);
      resp_in_val = 1'b1; resp_in_msg = MSG'(64'hD);
      #2;
      chk("t6_respD_val", 64'(resp_out_val), 64'd1);
      chk("t6_respD_msg", 64'(resp_out_msg), 64'hD);
      cyc();
      resp_in_val = 1'b0;
      chk("t6_end_inflight", 64'(num_inflight), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/lab2_proc_fetch_squash_unit.md
Name: lab2_proc_fetch_squash_unit

Overview:
Parametrised successor to the single-drop imem response drop unit. It sits between the fetch stage and the imem request/response ports. It tracks up to p_max_inflight outstanding fetch requests and applies credit-based backpressure on requests. On a squash (branch/jump redirect) it discards every response belonging to requests that were already in flight, so the processor can run more than one outstanding fetch.

Parameters:
p_msg_nbits, 47, width of the response message passed through (default equals $bits(mem_resp_4B_t)).
p_max_inflight, 2, maximum outstanding requests; legal range is 1 to 15.
c_cnt_nbits, $clog2(p_max_inflight+1), localparam; width of the counters.

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
squash  input  1  redirect; drop all responses to requests issued before this cycle
req_in_val  input  1  fetch wants to issue a request
req_in_rdy  output  1  request accepted this cycle
req_out_val  output  1  request valid toward the imem request queue
req_out_rdy  input  1  imem request queue ready
resp_in_msg  input  p_msg_nbits  response from imem
resp_in_val  input  1  response valid
resp_in_rdy  output  1  response consumed (delivered or dropped)
resp_out_msg  output  p_msg_nbits  response toward the decode side
resp_out_val  output  1  undropped response valid
resp_out_rdy  input  1  decode side ready
num_inflight  output  c_cnt_nbits  registered outstanding-request count
num_drop  output  c_cnt_nbits  registered count of pending drops

Behaviour:
- Reset (reset==0, asynchronous):
  - inflight_cnt=0, drop_cnt=0.
  - While reset is asserted, req_in_rdy, req_out_val, resp_in_rdy and resp_out_val are forced to 0.
- Events:
  - credit_ok = (inflight_cnt < p_max_inflight).
  - req_out_val = req_in_val & credit_ok; req_in_rdy = req_out_rdy & credit_ok.
  - req_fire = req_in_val & req_in_rdy.
  - No combinational path from resp_in to the request side: a response arriving at full credit frees credit only in the next cycle.
- Drop mode: drop_now = squash | (drop_cnt != 0).
  - When drop_now: resp_out_val=0, resp_in_rdy=1.
  - Otherwise: resp_out_val = resp_in_val, resp_in_rdy = resp_out_rdy.
  - resp_out_msg = resp_in_msg always (pure wire; zero latency).
  - resp_fire = resp_in_val & resp_in_rdy.
- inflight_cnt next = inflight_cnt + req_fire - resp_fire.
  - A request and a response in the same cycle leave the count unchanged.
- drop_cnt next:
  - If squash: inflight_cnt - resp_fire. This is a full reload, not an accumulation, so repeated squashes never exceed the in-flight count.
  - Else if drop_cnt!=0 and resp_fire: drop_cnt - 1.
  - Else: hold.
- Same-cycle rules:
  - A request fired in the squash cycle belongs to the new path and is NOT dropped.
  - A response arriving in the squash cycle IS dropped.
- Invariant: drop_cnt <= inflight_cnt. Responses return in order, so dropped responses are always the oldest.
- Error: resp_in_val while inflight_cnt==0 is a protocol violation.
  - Under `ifndef SYNTHESIS, an assertion flags it.
  - Counters never wrap below 0.
- Reset mid-operation clears both counters immediately. Responses still in flight after reset are the environment's responsibility.

Decomposition:
- Shared header/package: counter width function and response-message typedef reuse (mem_resp_4B_t from the mem-msgs header).
- One natural sub-module: lab2_proc_updown_counter (parametrised width, inc/dec/load/load_val, asynchronous active-low clear). It is instantiated twice: inflight and drop.

Test Plan:
- Basic pass-through, MAX=2: issue 2 requests, then req_in_val held with no responses -> req_in_rdy=0 and num_inflight=2. Return responses 0xA,0xB -> both delivered in order; num_inflight returns to 0.
- Squash with 2 in flight, no response that cycle: squash=1 -> num_drop=2 next cycle. Next two responses are consumed with resp_out_val=0; a third request's response 0xC is delivered.
- Squash with a response arriving in the same cycle, inflight=2: response dropped that cycle; num_drop=1; a request fired in the squash cycle survives and its response is delivered.
- Back-to-back squashes, MAX=4: squash at inflight=3, then again one cycle later after one dropped response -> num_drop reloads to 2 (never exceeds num_inflight). After the two drops, new responses pass.
- Backpressure: resp_out_rdy=0 in normal mode -> resp_in_rdy=0 and count held. In drop mode with resp_out_rdy=0 -> response still consumed.
- Reset asserted mid-operation (inflight=2, num_drop=1) -> counters read 0 asynchronously and all handshake outputs are 0. After release, a fresh request/response (0xD) passes normally.
